// File: rtl/unified_buffer_mc_pkg.sv
// ub_pkg: shared state type and lane/width defaults for the unified buffer family
package ub_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int LANES_DEF = 4;
  typedef enum logic {CLEAR, READY} ub_state_t;
endpackage

// File: rtl/unified_buffer_mc_mem_bank.sv
// ub_mem_bank: LANES-wide write / LANES-wide registered-read storage, no reset
//   clk   : clock
//   we    : write enable, lane k stored at waddr+k
//   re    : read enable, rdata loads lanes from raddr+k (read-first vs same-cycle write)
//   rdata : holds its value between reads
module ub_mem_bank
  import ub_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = 64,
  parameter int LANES = LANES_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [LANES*DATA_W-1:0] wdata,
  input  logic                    re,
  input  logic [ADDR_W-1:0]       raddr,
  output logic [LANES*DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (we) mem[waddr + ADDR_W'(k)] <= wdata[k*DATA_W +: DATA_W];
      if (re) rdata[k*DATA_W +: DATA_W] <= mem[raddr + ADDR_W'(k)];
    end
  end
endmodule

// File: rtl/unified_buffer_mc.sv
// unified_buffer_mc: lane-wide scratch buffer with zeroing sweep, auto/explicit writes and 1-cycle reads
//   clk, reset (async active-low)
//   wr_valid/wr_ready/wr_auto/wr_addr/wr_data : write beat, base = wr_ptr or wr_addr
//   rd_req/rd_addr -> rd_valid/rd_data        : read beat, data one cycle later
//   wr_ptr : internal write pointer; busy : clear sweep running; err : sticky out-of-range
module unified_buffer_mc
  import ub_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = 64,
  parameter int LANES = LANES_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic                    wr_auto,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [LANES*DATA_W-1:0] wr_data,
  input  logic                    rd_req,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic                    rd_valid,
  output logic [LANES*DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0]       wr_ptr,
  output logic                    busy,
  output logic                    err
);
  ub_state_t state;
  logic [ADDR_W-1:0] clr_addr, wr_base;
  logic [LANES*DATA_W-1:0] bank_rdata;
  logic have_read, wr_fire, rd_fire, wr_ok, rd_ok, bad;
  // a beat must fit entirely below DEPTH; addresses never wrap inside a beat
  function automatic logic fits(input logic [ADDR_W-1:0] b);
    return ({1'b0, b} + (ADDR_W+1)'(LANES)) <= (ADDR_W+1)'(DEPTH);
  endfunction
  assign wr_ready = state == READY;
  assign busy = state == CLEAR;
  // the bank has no reset, so rd_data reads as zero until the first completed read
  assign rd_data = have_read ? bank_rdata : '0;
  always_comb begin
    wr_base = wr_auto ? wr_ptr : wr_addr;
    wr_fire = wr_valid & wr_ready;
    rd_fire = rd_req & wr_ready;
    wr_ok = wr_fire & fits(wr_base);
    rd_ok = rd_fire & fits(rd_addr);
    bad = (wr_fire & ~wr_ok) | (rd_fire & ~rd_ok);
  end
  ub_mem_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LANES(LANES)) u_bank (
    .clk  (clk),
    .we   (busy | wr_ok),
    .waddr(busy ? clr_addr : wr_base),
    .wdata(busy ? '0 : wr_data),
    .re   (rd_ok),
    .raddr(rd_addr),
    .rdata(bank_rdata)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CLEAR;
      clr_addr <= '0;
      wr_ptr <= '0;
      rd_valid <= 1'b0;
      have_read <= 1'b0;
      err <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      have_read <= have_read | rd_ok;
      if (bad) err <= 1'b1;
      if (wr_ok) wr_ptr <= wr_base + ADDR_W'(LANES);
      if (state == CLEAR) begin
        clr_addr <= clr_addr + ADDR_W'(LANES);
        if (clr_addr == ADDR_W'(DEPTH - LANES)) state <= READY;
      end
    end
  end
endmodule

// File: tb/tb_unified_buffer_mc.sv
// tb_unified_buffer_mc: directed + random stimulus against a byte-array reference model
module tb_unified_buffer_mc;
  logic clk = 0, reset = 0;
  logic wr_valid = 0, wr_auto = 0, rd_req = 0;
  logic [5:0] wr_addr = 0, rd_addr = 0;
  logic [31:0] wr_data = 0;
  logic wr_ready, rd_valid, busy, err;
  logic [31:0] rd_data;
  logic [5:0] wr_ptr;
  int n_chk = 0, n_pass = 0;
  logic [7:0] m_mem [64];
  int m_ptr;
  logic m_err;
  logic [31:0] m_rd;
  unified_buffer_mc dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_auto(wr_auto),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .wr_ptr(wr_ptr), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [31:0] lanes(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction
  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
    m_ptr = 0;
    m_err = 0;
    m_rd = 0;
  endtask
  task automatic check_reset_state(input string tag);
    check({tag, ".busy"}, busy, 1);
    check({tag, ".wr_ready"}, wr_ready, 0);
    check({tag, ".wr_ptr"}, wr_ptr, 0);
    check({tag, ".rd_valid"}, rd_valid, 0);
    check({tag, ".rd_data"}, rd_data, 0);
    check({tag, ".err"}, err, 0);
  endtask
  task automatic wait_sweep(input string tag);
    int n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (busy && n < 100);
    check({tag, ".sweep_cycles"}, n, 16);
    check({tag, ".wr_ready"}, wr_ready, 1);
  endtask
  task automatic cyc(input string tag, input logic wv, input logic wa, input logic [5:0] wad,
                     input logic [31:0] wd, input logic rr, input logic [5:0] ra);
    logic rv;
    int b;
    @(negedge clk);
    wr_valid = wv; wr_auto = wa; wr_addr = wad; wr_data = wd; rd_req = rr; rd_addr = ra;
    @(posedge clk);
    rv = 0;
    if (rr) begin
      if (int'(ra) + 4 > 64) m_err = 1;
      else begin
        rv = 1;
        for (int k = 0; k < 4; k++) m_rd[k*8 +: 8] = m_mem[int'(ra) + k];
      end
    end
    if (wv) begin
      b = wa ? m_ptr : int'(wad);
      if (b + 4 > 64) m_err = 1;
      else begin
        for (int k = 0; k < 4; k++) m_mem[b + k] = wd[k*8 +: 8];
        m_ptr = (b + 4) % 64;
      end
    end
    #1;
    check({tag, ".rd_valid"}, rd_valid, rv);
    check({tag, ".rd_data"}, rd_data, m_rd);
    check({tag, ".wr_ptr"}, wr_ptr, m_ptr);
    check({tag, ".err"}, err, m_err);
  endtask
  task automatic idle();
    cyc("idle", 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1 check_reset_state("rst");
    @(negedge clk) reset = 1;
    wait_sweep("boot");
    cyc("rd3c", 0, 0, 0, 0, 1, 6'h3c);
    idle();
    for (int i = 0; i < 17; i++) cyc("auto", 1, 1, 0, lanes(11, 12, 21, 22), 0, 0);
    check("auto.ptr_after17", wr_ptr, 4);
    check("auto.err_clear", err, 0);
    cyc("rd0", 0, 0, 0, 0, 1, 6'h00);
    cyc("wr1e", 1, 0, 6'h1e, lanes(1, 2, 3, 4), 0, 0);
    check("wr1e.ptr", wr_ptr, 6'h22);
    cyc("rd1e", 0, 0, 0, 0, 1, 6'h1e);
    check("rd1e.lanes", rd_data, lanes(1, 2, 3, 4));
    idle();
    cyc("wr3e", 1, 0, 6'h3e, lanes(7, 7, 7, 7), 0, 0);
    check("wr3e.err", err, 1);
    cyc("rd3d", 0, 0, 0, 0, 1, 6'h3d);
    cyc("rd3c_after", 0, 0, 0, 0, 1, 6'h3c);
    cyc("rd10_pre", 0, 0, 0, 0, 1, 6'h10);
    cyc("rw10", 1, 0, 6'h10, lanes(9, 9, 9, 9), 1, 6'h10);
    check("rw10.old", rd_data, lanes(11, 12, 21, 22));
    cyc("rd10", 0, 0, 0, 0, 1, 6'h10);
    check("rd10.new", rd_data, lanes(9, 9, 9, 9));
    for (int i = 0; i < 300; i++)
      cyc("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 6'($urandom_range(0, 63)),
          $urandom, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
    for (int i = 0; i < 16; i++) cyc("b2b", 0, 0, 0, 0, 1, 6'(i * 3));
    @(negedge clk);
    wr_valid = 0; rd_req = 0;
    reset = 0;
    #1 check_reset_state("rst2");
    @(negedge clk) reset = 1;
    repeat (7) @(posedge clk);
    #2 reset = 0;
    #1 check_reset_state("midsweep");
    @(negedge clk) reset = 1;
    model_clear();
    wait_sweep("resweep");
    for (int i = 0; i < 16; i++) cyc("zero", 0, 0, 0, 0, 1, 6'(i * 4));
    idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/unified_buffer_mc.md
UNIFIED_BUFFER_MC -- requirements
Module: unified_buffer_mc

Interface
REQ-001 Parameter DATA_W, default 8, element width in bits.
REQ-002 Parameter DEPTH, default 64, element count; power of two and a multiple of LANES.
REQ-003 Parameter LANES, default 4, elements moved per write or read beat.
REQ-004 Derived localparam ADDR_W = clog2(DEPTH).
REQ-005 clk  in  1  single clock; all state on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low; the block is in reset while reset=0.
REQ-007 wr_valid  in  1  write beat offered.
REQ-008 wr_ready  out  1  block can accept a write beat.
REQ-009 wr_auto  in  1  1 = write at the internal write pointer; 0 = write at wr_addr.
REQ-010 wr_addr  in  ADDR_W  base element address for an explicit write.
REQ-011 wr_data  in  LANES*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
REQ-012 rd_req  in  1  read beat request.
REQ-013 rd_addr  in  ADDR_W  base element address for a read.
REQ-014 rd_valid  out  1  rd_data holds a completed read.
REQ-015 rd_data  out  LANES*DATA_W  read elements, same lane packing as wr_data.
REQ-016 wr_ptr  out  ADDR_W  current internal write pointer.
REQ-017 busy  out  1  clear sweep in progress.
REQ-018 err  out  1  sticky out-of-range flag.

Function
REQ-019 The FSM SHALL have two states: CLEAR and READY.
REQ-020 CLEAR is entered on reset; leaving reset, it writes zero to LANES elements per cycle from address 0 for DEPTH/LANES cycles, then enters READY.
REQ-021 busy=1 and wr_ready=0 in CLEAR; rd_req is ignored in CLEAR.
REQ-022 In READY, wr_ready=1; a write occurs on a cycle with wr_valid & wr_ready.
REQ-023 Write base = wr_ptr if wr_auto=1, else wr_addr; lane k is stored at base+k.
REQ-024 An auto write advances wr_ptr by LANES modulo DEPTH, wrapping to 0 with no error.
REQ-025 An explicit write sets wr_ptr = wr_addr+LANES modulo DEPTH.
REQ-026 An explicit write or read with base+LANES > DEPTH is dropped (no memory change, no rd_valid) and sets err; no address wrap within a beat.
REQ-027 A read accepted in cycle N drives rd_data and asserts rd_valid=1 in cycle N+1; rd_valid is 1 for exactly one cycle per request, with no back-pressure.
REQ-028 rd_data holds its value until the next accepted read.
REQ-029 A read and a write in the same cycle at overlapping addresses return the pre-write data (read-first).
REQ-030 Back-to-back reads on consecutive cycles are supported at one beat per cycle.

Reset
REQ-031 On reset assertion, wr_ptr=0, rd_valid=0, rd_data=0, err=0, busy=1, wr_ready=0, state=CLEAR.
REQ-032 Reset asserted mid-sweep or mid-operation restarts CLEAR from address 0.
REQ-033 err is cleared only by reset.

Structure
REQ-034 Package ub_pkg SHALL hold the state enum type (ub_state_t) and the DATA_W/LANES defaults shared with the accumulator and input-setup blocks.
REQ-035 The storage array SHALL be one sub-module, ub_mem_bank: LANES-wide write, LANES-wide registered read, no reset; it is cleared only by the CLEAR sweep.

Verification
REQ-036 Release reset, count cycles -> busy=1 for exactly DEPTH/LANES=16 cycles, then wr_ready=1; a read of address 0x3C returns all zeros.
REQ-037 Auto writes of {11,12,21,22} x17 beats -> wr_ptr goes 0,4,...,60,0,4; the 17th beat overwrites address 0; err=0.
REQ-038 Explicit write {1,2,3,4} @0x1E, then read @0x1E -> rd_valid one cycle later, rd_data lanes {1,2,3,4}; wr_ptr=0x22.
REQ-039 Write @0x3E (base+4>64) -> memory unchanged, err=1 and stays 1; a read @0x3D -> no rd_valid.
REQ-040 Write {9,9,9,9} @0x10 while reading @0x10 in the same cycle -> rd_data returns the old data; a read next cycle returns 9s.
REQ-041 Assert reset during the 8th CLEAR cycle -> outputs at reset values; after release, a full 16-cycle sweep follows.
